// File: rtl/entropy_decode_dc_coefficients_if.sv
// Handshake bundle for the DC decoder: bitstream words in, reconstructed DC coefficients out.
interface entropy_decode_dc_coefficients_if;
    logic [31:0] bs_data;
    logic        bs_valid;
    logic        bs_ready;
    logic [31:0] dc_coeff;
    logic        dc_valid;
    logic        dc_ready;

    modport master (
        output bs_data, bs_valid, dc_ready,
        input  bs_ready, dc_coeff, dc_valid
    );

    modport slave (
        input  bs_data, bs_valid, dc_ready,
        output bs_ready, dc_coeff, dc_valid
    );
endinterface

// File: rtl/entropy_decode_dc_coefficients.sv
// Bit-serial ProRes DC decoder: adaptive exp-Golomb / Rice2 codewords to DC values with
// sign prediction, one bit consumed per cycle from a 64-bit word buffer.
module entropy_decode_dc_coefficients #(
    parameter int MAX_PREFIX = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [7:0]  i_dc_count,
    input  logic        i_flush,
    entropy_decode_dc_coefficients_if.slave bus,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [31:0] o_bits_consumed
);

    typedef enum logic [2:0] {
        S_IDLE, S_ZEROS, S_SUFFIX, S_RECON, S_OUT, S_ERROR
    } state_t;

    localparam logic [5:0] MAXP = 6'(MAX_PREFIX);

    state_t      r_state, w_state_n;
    logic [63:0] r_buf;
    logic [6:0]  r_fill;
    logic [31:0] r_bits;
    logic [7:0]  r_rem;
    logic        r_first;
    logic [2:0]  r_k;
    logic        r_rice;
    logic        r_off8;
    logic [5:0]  r_z;
    logic [6:0]  r_cnt;
    logic [31:0] r_w;
    logic [31:0] r_prev_dc;
    logic [31:0] r_prev_diff;
    logic [31:0] r_dc;
    logic        r_done;

    logic        w_have, w_bit, w_consume, w_escape, w_load;
    logic [5:0]  w_z_inc;
    logic [6:0]  w_sfx_len;
    logic [63:0] w_buf_c, w_buf_n;
    logic [6:0]  w_fill_c, w_fill_n;
    logic [31:0] w_val, w_coded, w_diff, w_dc, w_mag;
    logic [2:0]  w_cb_k;
    logic        w_cb_rice;

    assign w_have    = (r_fill != 7'd0);
    assign w_bit     = r_buf[63];
    assign w_z_inc   = r_z + 6'd1;
    assign w_escape  = r_rice && (r_z == 6'd1) && !w_bit;
    assign w_sfx_len = r_rice ? 7'd2 : ({1'b0, r_z} + {4'b0, r_k});

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_consume = 1'b0;
        case (r_state)
            S_IDLE, S_ERROR: begin
                if (i_start) w_state_n = (i_dc_count == 8'd0) ? S_IDLE : S_ZEROS;
            end
            S_ZEROS: begin
                if (w_have) begin
                    w_consume = 1'b1;
                    if (w_bit)
                        w_state_n = (w_sfx_len == 7'd0) ? S_RECON : S_SUFFIX;
                    else if (!w_escape && (w_z_inc > MAXP))
                        w_state_n = S_ERROR;
                end
            end
            S_SUFFIX: begin
                if (w_have) begin
                    w_consume = 1'b1;
                    if (r_cnt == 7'd1) w_state_n = S_RECON;
                end
            end
            S_RECON: w_state_n = S_OUT;
            S_OUT: begin
                if (bus.dc_ready) w_state_n = (r_rem == 8'd0) ? S_IDLE : S_ZEROS;
            end
            default: w_state_n = S_IDLE;
        endcase
        if (i_flush) begin
            w_state_n = S_IDLE;
            w_consume = 1'b0;
        end
    end

    // ---------------- bit buffer ----------------
    // New words land directly behind the bits still queued, after this cycle's consume.
    always_comb begin
        w_buf_c  = w_consume ? {r_buf[62:0], 1'b0} : r_buf;
        w_fill_c = r_fill - {6'b0, w_consume};
        w_load   = bus.bs_valid && bus.bs_ready;
        w_buf_n  = w_buf_c;
        w_fill_n = w_fill_c;
        if (w_load) begin
            w_buf_n  = w_buf_c | ({bus.bs_data, 32'b0} >> w_fill_c);
            w_fill_n = w_fill_c + 7'd32;
        end
        if (i_flush) begin
            w_buf_n  = 64'b0;
            w_fill_n = 7'd0;
        end
    end

    // ---------------- reconstruction ----------------
    always_comb begin
        if (r_rice)
            w_val = r_w - 32'd4 + {24'b0, r_z, 2'b00};
        else
            w_val = r_w - (32'd1 << r_k) + (r_off8 ? 32'd8 : 32'd0);
        w_coded = w_val[0] ? (32'd0 - ((w_val + 32'd1) >> 1)) : (w_val >> 1);
        w_diff  = r_prev_diff[31] ? (32'd0 - w_coded) : w_coded;
        w_dc    = r_prev_dc + w_diff;
    end

    // Next codebook from the magnitude of the last difference.
    always_comb begin
        w_mag     = r_prev_diff[31] ? (32'd0 - r_prev_diff) : r_prev_diff;
        w_cb_k    = 3'd3;
        w_cb_rice = 1'b0;
        case (w_mag)
            32'd0:   w_cb_k = 3'd0;
            32'd1:   w_cb_k = 3'd1;
            32'd2: begin
                w_cb_k    = 3'd0;
                w_cb_rice = 1'b1;
            end
            default: w_cb_k = 3'd3;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_buf       <= 64'b0;
            r_fill      <= 7'd0;
            r_bits      <= 32'd0;
            r_rem       <= 8'd0;
            r_first     <= 1'b0;
            r_k         <= 3'd0;
            r_rice      <= 1'b0;
            r_off8      <= 1'b0;
            r_z         <= 6'd0;
            r_cnt       <= 7'd0;
            r_w         <= 32'd0;
            r_prev_dc   <= 32'd0;
            r_prev_diff <= 32'd0;
            r_dc        <= 32'd0;
            r_done      <= 1'b0;
        end else begin
            r_buf  <= w_buf_n;
            r_fill <= w_fill_n;
            r_done <= 1'b0;
            if (w_consume) r_bits <= r_bits + 32'd1;
            if (!i_flush) begin
                case (r_state)
                    S_IDLE, S_ERROR: begin
                        if (i_start) begin
                            r_bits      <= 32'd0;
                            r_rem       <= i_dc_count;
                            r_first     <= 1'b1;
                            r_prev_dc   <= 32'd0;
                            r_prev_diff <= 32'd0;
                            r_k         <= 3'd5;
                            r_rice      <= 1'b0;
                            r_off8      <= 1'b0;
                            r_z         <= 6'd0;
                            if (i_dc_count == 8'd0) r_done <= 1'b1;
                        end
                    end
                    S_ZEROS: begin
                        if (w_consume) begin
                            if (w_bit) begin
                                r_w   <= 32'd1;
                                r_cnt <= w_sfx_len;
                            end else if (w_escape) begin
                                // Rice2 escape: continue as EG k3 with an offset of 8
                                r_rice <= 1'b0;
                                r_k    <= 3'd3;
                                r_off8 <= 1'b1;
                                r_z    <= 6'd0;
                            end else begin
                                r_z <= w_z_inc;
                            end
                        end
                    end
                    S_SUFFIX: begin
                        if (w_consume) begin
                            r_w   <= {r_w[30:0], w_bit};
                            r_cnt <= r_cnt - 7'd1;
                        end
                    end
                    S_RECON: begin
                        r_dc        <= w_dc;
                        r_prev_dc   <= w_dc;
                        r_prev_diff <= r_first ? 32'd3 : w_diff;
                        r_first     <= 1'b0;
                        r_rem       <= r_rem - 8'd1;
                    end
                    S_OUT: begin
                        if (bus.dc_ready) begin
                            if (r_rem == 8'd0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_k    <= w_cb_k;
                                r_rice <= w_cb_rice;
                                r_off8 <= 1'b0;
                                r_z    <= 6'd0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.bs_ready    = (r_fill <= 7'd32);
    assign bus.dc_coeff    = r_dc;
    assign bus.dc_valid    = (r_state == S_OUT);
    assign o_busy          = (r_state == S_ZEROS) || (r_state == S_SUFFIX) ||
                             (r_state == S_RECON) || (r_state == S_OUT);
    assign o_done          = r_done;
    assign o_error         = (r_state == S_ERROR);
    assign o_bits_consumed = r_bits;

endmodule

// File: tb/tb_entropy_decode_dc_coefficients.sv
// Directed bench for the DC decoder: known slices, split delivery, overflow and reset.
module tb_entropy_decode_dc_coefficients;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  dc_count;
    logic        flush;
    logic        busy, done, error;
    logic [31:0] bits_consumed;

    entropy_decode_dc_coefficients_if bus();

    entropy_decode_dc_coefficients #(.MAX_PREFIX(16)) dut (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_start         (start),
        .i_dc_count      (dc_count),
        .i_flush         (flush),
        .bus             (bus),
        .o_busy          (busy),
        .o_done          (done),
        .o_error         (error),
        .o_bits_consumed (bits_consumed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wq[$];
    int          gq[$];
    logic [31:0] obs[$];
    bit          done_seen, err_seen, valid_seen;
    int          unstable;
    logic [31:0] bits_at_err;

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        bus.bs_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Runs one slice: feeds wq (with gq idle cycles before each word) and drains outputs,
    // holding dc_ready low for 'stall' cycles on each coefficient.
    task automatic run_slice(input logic [7:0] n, input int stall, input int max_cyc);
        int widx = 0;
        int gcnt = 0;
        int scnt = 0;
        bit holding = 0;
        logic [31:0] held = '0;
        obs.delete();
        done_seen = 0; err_seen = 0; valid_seen = 0; unstable = 0; bits_at_err = '0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (c > 0 && done) begin done_seen = 1; break; end
            if (c > 0 && error) begin err_seen = 1; bits_at_err = bits_consumed; break; end
            start    = (c == 0);
            dc_count = n;
            if (widx < wq.size()) begin
                if (gcnt < gq[widx]) begin
                    bus.bs_valid = 1'b0;
                    gcnt++;
                end else begin
                    bus.bs_valid = 1'b1;
                    bus.bs_data  = wq[widx];
                    if (bus.bs_ready) begin widx++; gcnt = 0; end
                end
            end else begin
                bus.bs_valid = 1'b0;
            end
            if (bus.dc_valid) begin
                valid_seen = 1;
                if (holding && bus.dc_coeff !== held) unstable++;
                if (!holding) begin holding = 1; held = bus.dc_coeff; end
                if (scnt < stall) begin
                    bus.dc_ready = 1'b0;
                    scnt++;
                end else begin
                    bus.dc_ready = 1'b1;
                    obs.push_back(bus.dc_coeff);
                    holding = 0;
                    scnt = 0;
                end
            end else begin
                bus.dc_ready = 1'b0;
            end
        end
        start = 1'b0;
        bus.bs_valid = 1'b0;
        bus.dc_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.dc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dc_valid got %0b want 0", bus.dc_valid); end
        n_checks++; if (bus.dc_coeff !== 32'd0) begin n_fail++; $display("FAIL reset_dc_coeff got %0h want 0", bus.dc_coeff); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %0b want 0", error); end
        n_checks++; if (bits_consumed !== 32'd0) begin n_fail++; $display("FAIL reset_bits got %0d want 0", bits_consumed); end
        n_checks++; if (bus.bs_ready !== 1'b1) begin n_fail++; $display("FAIL reset_bs_ready got %0b want 1", bus.bs_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_two_coeff();
        logic [31:0] exp_v [2] = '{32'd0, 32'd0};
        do_flush();
        wq = '{32'h82000000}; gq = '{0};
        run_slice(8'd2, 0, 300);
        n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL two_done got %0b want 1", done_seen); end
        n_checks++; if (obs.size() !== 2) begin n_fail++; $display("FAIL two_count got %0d want 2", obs.size()); end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (((i < obs.size()) ? obs[i] : 32'hDEADBEEF) !== exp_v[i]) begin
                n_fail++; $display("FAIL two_dc[%0d] got %0d want %0d", i, (i < obs.size()) ? obs[i] : 32'hDEADBEEF, exp_v[i]);
            end
        end
        n_checks++; if (bits_consumed !== 32'd10) begin n_fail++; $display("FAIL two_bits got %0d want 10", bits_consumed); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL two_done_pulse got %0b want 0", done); end
    endtask

    task automatic test_sign_rice();
        logic [31:0] exp_v [3] = '{32'd5, 32'd3, 32'd4};
        do_flush();
        wq = '{32'hAAE80000}; gq = '{0};
        run_slice(8'd3, 0, 300);
        n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL sign_done got %0b want 1", done_seen); end
        n_checks++; if (obs.size() !== 3) begin n_fail++; $display("FAIL sign_count got %0d want 3", obs.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (((i < obs.size()) ? obs[i] : 32'hDEADBEEF) !== exp_v[i]) begin
                n_fail++; $display("FAIL sign_dc[%0d] got %0d want %0d", i, (i < obs.size()) ? obs[i] : 32'hDEADBEEF, exp_v[i]);
            end
        end
        n_checks++; if (bits_consumed !== 32'd13) begin n_fail++; $display("FAIL sign_bits got %0d want 13", bits_consumed); end
    endtask

    task automatic test_rice_escape();
        logic [31:0] exp_v [3] = '{32'd0, 32'd2, 32'd7};
        do_flush();
        wq = '{32'h830A0000}; gq = '{0};
        run_slice(8'd3, 0, 300);
        n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL esc_done got %0b want 1", done_seen); end
        n_checks++; if (obs.size() !== 3) begin n_fail++; $display("FAIL esc_count got %0d want 3", obs.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (((i < obs.size()) ? obs[i] : 32'hDEADBEEF) !== exp_v[i]) begin
                n_fail++; $display("FAIL esc_dc[%0d] got %0d want %0d", i, (i < obs.size()) ? obs[i] : 32'hDEADBEEF, exp_v[i]);
            end
        end
        n_checks++; if (bits_consumed !== 32'd16) begin n_fail++; $display("FAIL esc_bits got %0d want 16", bits_consumed); end
    endtask

    // A 24-bit EG k5 codeword (9 zeros) leaves bytes AA in the buffer so the next
    // slice sees the stream AA E8 across a word boundary.
    task automatic test_split_backpressure();
        logic [31:0] exp_v [3] = '{32'd5, 32'd3, 32'd4};
        do_flush();
        wq = '{32'h004000AA}; gq = '{0};
        run_slice(8'd1, 0, 300);
        n_checks++; if (((obs.size() > 0) ? obs[0] : 32'hDEADBEEF) !== 32'd8176) begin
            n_fail++; $display("FAIL split_pre_dc got %0d want 8176", (obs.size() > 0) ? obs[0] : 32'hDEADBEEF);
        end
        n_checks++; if (bits_consumed !== 32'd24) begin n_fail++; $display("FAIL split_pre_bits got %0d want 24", bits_consumed); end
        wq = '{32'hE8000000}; gq = '{3};
        run_slice(8'd3, 5, 600);
        n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL split_done got %0b want 1", done_seen); end
        n_checks++; if (obs.size() !== 3) begin n_fail++; $display("FAIL split_count got %0d want 3", obs.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (((i < obs.size()) ? obs[i] : 32'hDEADBEEF) !== exp_v[i]) begin
                n_fail++; $display("FAIL split_dc[%0d] got %0d want %0d", i, (i < obs.size()) ? obs[i] : 32'hDEADBEEF, exp_v[i]);
            end
        end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL split_stable got %0d changes want 0", unstable); end
        n_checks++; if (bits_consumed !== 32'd13) begin n_fail++; $display("FAIL split_bits got %0d want 13", bits_consumed); end
    endtask

    task automatic test_prefix_overflow();
        do_flush();
        wq = '{32'h00000000, 32'h00000000}; gq = '{0, 0};
        run_slice(8'd1, 0, 200);
        n_checks++; if (err_seen !== 1'b1) begin n_fail++; $display("FAIL ovf_error got %0b want 1", err_seen); end
        n_checks++; if (bits_at_err !== 32'd17) begin n_fail++; $display("FAIL ovf_bits got %0d want 17", bits_at_err); end
        n_checks++; if (valid_seen !== 1'b0) begin n_fail++; $display("FAIL ovf_no_valid got %0b want 0", valid_seen); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy got %0b want 0", busy); end
        repeat (3) @(negedge clk);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b want 1", error); end
        do_flush();
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL ovf_flush_error got %0b want 0", error); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_flush_busy got %0b want 0", busy); end
        n_checks++; if (bus.bs_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_flush_ready got %0b want 1", bus.bs_ready); end
    endtask

    task automatic test_reset_mid_decode();
        logic [31:0] exp_v [3] = '{32'd5, 32'd3, 32'd4};
        do_flush();
        @(negedge clk);
        start = 1'b1; dc_count = 8'd3;
        bus.bs_valid = 1'b1; bus.bs_data = 32'hAAE80000;
        @(negedge clk);
        start = 1'b0; bus.bs_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bits_consumed !== 32'd3) begin n_fail++; $display("FAIL rst_mid_bits got %0d want 3", bits_consumed); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy got %0b want 1", busy); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", busy); end
        n_checks++; if (bits_consumed !== 32'd0) begin n_fail++; $display("FAIL rst_bits got %0d want 0", bits_consumed); end
        n_checks++; if (bus.dc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", bus.dc_valid); end
        n_checks++; if (bus.bs_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %0b want 1", bus.bs_ready); end
        n_checks++; if (error !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_flags got err=%0b done=%0b want 0 0", error, done); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wq = '{32'hAAE80000}; gq = '{0};
        run_slice(8'd3, 0, 300);
        n_checks++; if (obs.size() !== 3) begin n_fail++; $display("FAIL rerun_count got %0d want 3", obs.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (((i < obs.size()) ? obs[i] : 32'hDEADBEEF) !== exp_v[i]) begin
                n_fail++; $display("FAIL rerun_dc[%0d] got %0d want %0d", i, (i < obs.size()) ? obs[i] : 32'hDEADBEEF, exp_v[i]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; dc_count = 8'd0; flush = 1'b0;
        bus.bs_data = 32'd0; bus.bs_valid = 1'b0; bus.dc_ready = 1'b0;
        test_reset();
        test_two_coeff();
        test_sign_rice();
        test_rice_escape();
        test_split_backpressure();
        test_prefix_overflow();
        test_reset_mid_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
